// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed multiply/divide unit for the execute stage.
// A start pulse (ctrl_MULT or ctrl_DIV) latches the operands. The unit then
// runs WIDTH iteration edges: radix-2 Booth for multiply, or non-restoring
// division on magnitudes for divide. It raises data_resultRDY for one cycle
// with the result and exception flag. busy stalls the pipeline from the
// capture edge until the DONE state ends.
//
// Ports:
//   clock           system clock, rising edge
//   ctrl_reset      synchronous active-high reset
//   data_operandA   signed multiplicand / dividend (sampled on capture edge)
//   data_operandB   signed multiplier / divisor (sampled on capture edge)
//   ctrl_MULT       start-multiply pulse (wins if ctrl_DIV is also high)
//   ctrl_DIV        start-divide pulse
//   data_result     low WIDTH bits of product, or quotient
//   data_exception  multiply overflow, divide-by-zero or MOST_NEG/-1
//   data_resultRDY  one-cycle completion pulse
//   busy            operation in flight
//
// Optional feature: define MULTDIV_EARLY_EXIT_EN to let a multiply with a
// zero operand, or a divide by zero, complete one edge after capture.
module multdiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH + 1;   // Booth register {acc, multiplier, q-1}
    localparam int unsigned RW = WIDTH + 2;       // partial remainder, holds +/- 2*divisor
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;     // multiplicand, or divisor magnitude
    logic [RW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             neg_q, neg_d;         // quotient sign
    logic             dz_q, dz_d;           // divide by zero
    logic             ovf_q, ovf_d;         // MOST_NEG / -1
    logic             early_q, early_d;     // commit on first edge after capture
    logic [WIDTH-1:0] result_d;
    logic             exc_d, rdy_d, busy_d;

    logic [WIDTH:0]     booth_acc, booth_m, booth_sum;
    logic [PW-1:0]      prod_step;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     prod_top;
    logic               mul_ovf;
    logic [RW-1:0]      dvs_ext, rem_sh, rem_step;
    logic [WIDTH-1:0]   quo_step, div_res;
    logic               div_exc;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Operand magnitudes; MOST_NEG maps onto itself, which is its correct unsigned magnitude
    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? WIDTH'(-data_operandA) : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? WIDTH'(-data_operandB) : data_operandB;
    end

    // One Booth step; the accumulator is widened by one bit so +/-MOST_NEG cannot wrap
    always_comb begin
        booth_acc = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
        booth_m   = {mcand_q[WIDTH-1], mcand_q};
        case (prod_q[1:0])
            2'b01:   booth_sum = booth_acc + booth_m;
            2'b10:   booth_sum = booth_acc - booth_m;
            default: booth_sum = booth_acc;
        endcase
        prod_step = {booth_sum, prod_q[WIDTH:1]};
        product   = prod_step[PW-1:1];
        prod_top  = product[2*WIDTH-1:WIDTH-1];
        mul_ovf   = !((prod_top == '0) || (prod_top == '1));
    end

    // One non-restoring division step plus final sign and special-case selection
    always_comb begin
        dvs_ext  = {2'b00, mcand_q};
        rem_sh   = {rem_q[RW-2:0], quo_q[WIDTH-1]};
        rem_step = rem_q[RW-1] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
        quo_step = {quo_q[WIDTH-2:0], ~rem_step[RW-1]};
        if (dz_q) begin
            div_res = '0;
            div_exc = 1'b1;
        end else if (ovf_q) begin
            div_res = MOST_NEG;
            div_exc = 1'b1;
        end else begin
            div_res = neg_q ? WIDTH'(-quo_step) : quo_step;
            div_exc = 1'b0;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        early_d  = early_q;
        result_d = data_result;
        exc_d    = data_exception;
        rdy_d    = 1'b0;
        busy_d   = busy;

        case (state_q)
            IDLE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    state_d = ctrl_MULT ? MUL : DIV;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
                    mcand_d = ctrl_MULT ? data_operandA : b_mag;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    dz_d    = (data_operandB == '0);
                    ovf_d   = (data_operandA == MOST_NEG) && (data_operandB == '1);
`ifdef MULTDIV_EARLY_EXIT_EN
                    early_d = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                        : (data_operandB == '0);
`else
                    early_d = 1'b0;
`endif
                end
            end
            MUL: begin
                if (early_q) begin
                    result_d = '0;
                    exc_d    = 1'b0;
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    prod_d = prod_step;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        result_d = product[WIDTH-1:0];
                        exc_d    = mul_ovf;
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DIV: begin
                if (early_q) begin
                    result_d = div_res;
                    exc_d    = div_exc;
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        result_d = div_res;
                        exc_d    = div_exc;
                        rdy_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            prod_q         <= '0;
            mcand_q        <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            neg_q          <= 1'b0;
            dz_q           <= 1'b0;
            ovf_q          <= 1'b0;
            early_q        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prod_q         <= prod_d;
            mcand_q        <= mcand_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            neg_q          <= neg_d;
            dz_q           <= dz_d;
            ovf_q          <= ovf_d;
            early_q        <= early_d;
            data_result    <= result_d;
            data_exception <= exc_d;
            data_resultRDY <= rdy_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: self-checking bench for multdiv_seq.
// Expected results come from a behavioural model and are queued when an
// operation is started. They are popped and compared when data_resultRDY is
// seen. Latency is counted in rising edges after the capture edge.
module tb_multdiv_seq;

    localparam int unsigned WIDTH = 32;
`ifdef MULTDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    multdiv_seq #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Behavioural reference: 64-bit signed product, or truncating signed divide
    function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          sa;
        int          sb_;
        longint      p;
        logic [63:0] pv;
        sa    = $signed(a);
        sb_   = $signed(b);
        e.lat = WIDTH;
        if (m) begin
            p     = longint'(sa) * longint'(sb_);
            pv    = 64'(p);
            e.res = pv[31:0];
            e.exc = !((pv[63:31] == 33'h0) || (pv[63:31] == {33{1'b1}}));
            if (EARLY && (a == 32'd0 || b == 32'd0)) e.lat = 1;
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            if (EARLY) e.lat = 1;
        end else if (a == MIN && b == 32'hFFFF_FFFF) begin
            e.res = MIN;
            e.exc = 1'b1;
        end else begin
            e.res = 32'(sa / sb_);
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Bounded wait for the ready pulse, counting edges from k0
    task automatic wait_rdy(input int k0, output int k, output bit seen);
        k    = k0;
        seen = 1'b0;
        for (int i = 0; i < int'(WIDTH) + 8 && !seen; i++) begin
            @(negedge clock);
            k++;
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
    endtask

    // Start one operation (called at a negedge), queue its expectation, collect its outcome
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic x, output int k, output bit seen,
                         output logic busy0, output logic after_ok);
        sb.push_back(model(m, a, b));
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        busy0 = busy;
        wait_rdy(0, k, seen);
        r = data_result;
        x = data_exception;
        @(negedge clock);
        after_ok = (data_resultRDY === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        int rdy_cnt = 0;
        int busy_cnt = 0;
        ctrl_reset = 1'b1;
        repeat (3) @(negedge clock);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) rdy_cnt++;
            if (busy !== 1'b0) busy_cnt++;
        end
        total++; if (data_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", data_result); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL reset_busy busy cycles=%0d exp=0", busy_cnt); end
        total++; if (rdy_cnt != 0) begin bad++; $display("FAIL reset_rdy rdy cycles=%0d exp=0", rdy_cnt); end
    endtask

    task automatic test_mult();
        logic [31:0] ta[9] = '{32'hFFFF_FFF9, 32'h0001_0000, 32'h7FFF_FFFF, 32'h0000_0000, MIN,
                               MIN, 32'hFFFF_FFFF, 32'h0001_2345, 32'h0000_0003};
        logic [31:0] tb_[9] = '{32'd6, 32'h0001_0000, 32'd1, 32'h0000_1234, MIN,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_9877, 32'h0000_0000};
        logic [31:0] a, b, r;
        logic x, b0, ok;
        int k;
        bit seen;
        exp_t e;
        for (int i = 0; i < 15; i++) begin
            if (i < 9) begin a = ta[i]; b = tb_[i]; end
            else begin a = $urandom; b = (i % 2 == 0) ? $urandom : 32'($urandom_range(65535)); end
            do_op(1'b1, 1'b0, a, b, r, x, k, seen, b0, ok);
            e = sb.pop_front();
            total++; if (b0 !== 1'b1) begin bad++; $display("FAIL mult_busy a=%h b=%h got=%b exp=1", a, b, b0); end
            total++; if (!seen || k != e.lat) begin bad++; $display("FAIL mult_latency a=%h b=%h got=%0d seen=%0d exp=%0d", a, b, k, seen, e.lat); end
            total++; if (r !== e.res) begin bad++; $display("FAIL mult_result a=%h b=%h got=%h exp=%h", a, b, r, e.res); end
            total++; if (x !== e.exc) begin bad++; $display("FAIL mult_exc a=%h b=%h got=%b exp=%b", a, b, x, e.exc); end
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL mult_rdy_end a=%h b=%h rdy/busy not low after DONE", a, b); end
        end
    endtask

    task automatic test_div();
        logic [31:0] ta[11] = '{32'hFFFF_FFEF, 32'd100, MIN, 32'd17, 32'hFFFF_FFEF, 32'd7,
                                MIN, MIN, 32'd0, 32'h7FFF_FFFF, 32'd1};
        logic [31:0] tb_[11] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd2,
                                 32'd1, 32'd2, 32'd5, 32'h7FFF_FFFF, MIN};
        logic [31:0] a, b, r, last_r;
        logic x, last_x, b0, ok;
        int k;
        bit seen;
        exp_t e;
        last_r = '0;
        last_x = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 11) begin a = ta[i]; b = tb_[i]; end
            else begin a = $urandom; b = (i % 2 == 0) ? $urandom : (32'($urandom_range(20)) - 32'd10); end
            do_op(1'b0, 1'b1, a, b, r, x, k, seen, b0, ok);
            e = sb.pop_front();
            last_r = e.res;
            last_x = e.exc;
            total++; if (b0 !== 1'b1) begin bad++; $display("FAIL div_busy a=%h b=%h got=%b exp=1", a, b, b0); end
            total++; if (!seen || k != e.lat) begin bad++; $display("FAIL div_latency a=%h b=%h got=%0d seen=%0d exp=%0d", a, b, k, seen, e.lat); end
            total++; if (r !== e.res) begin bad++; $display("FAIL div_result a=%h b=%h got=%h exp=%h", a, b, r, e.res); end
            total++; if (x !== e.exc) begin bad++; $display("FAIL div_exc a=%h b=%h got=%b exp=%b", a, b, x, e.exc); end
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL div_rdy_end a=%h b=%h rdy/busy not low after DONE", a, b); end
        end
        repeat (4) @(negedge clock);
        total++; if (data_result !== last_r || data_exception !== last_x) begin
            bad++; $display("FAIL div_hold got=%h/%b exp=%h/%b", data_result, data_exception, last_r, last_x);
        end
    endtask

    task automatic test_ignore();
        logic [31:0] r;
        logic x, b0, ok;
        int k;
        bit seen;
        int busy_cnt = 0;
        exp_t e;
        sb.push_back(model(1'b1, 32'hFFFE_1DC0, 32'd789));
        ctrl_MULT = 1'b1; data_operandA = 32'hFFFE_1DC0; data_operandB = 32'd789;
        @(negedge clock);
        ctrl_MULT = 1'b0; data_operandA = 32'd50; data_operandB = 32'd7;
        repeat (9) @(negedge clock);
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        wait_rdy(10, k, seen);
        r = data_result;
        x = data_exception;
        e = sb.pop_front();
        total++; if (!seen || k != e.lat) begin bad++; $display("FAIL ignore_latency got=%0d seen=%0d exp=%0d", k, seen, e.lat); end
        total++; if (r !== e.res) begin bad++; $display("FAIL ignore_result got=%h exp=%h", r, e.res); end
        total++; if (x !== e.exc) begin bad++; $display("FAIL ignore_exc got=%b exp=%b", x, e.exc); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || data_resultRDY !== 1'b0) busy_cnt++;
        end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL ignore_no_queue active cycles=%0d exp=0", busy_cnt); end
        do_op(1'b1, 1'b1, 32'hFFFF_FFF6, 32'd12, r, x, k, seen, b0, ok);
        e = sb.pop_front();
        total++; if (!seen || k != e.lat) begin bad++; $display("FAIL both_latency got=%0d seen=%0d exp=%0d", k, seen, e.lat); end
        total++; if (r !== e.res) begin bad++; $display("FAIL both_result got=%h exp=%h", r, e.res); end
        total++; if (x !== e.exc) begin bad++; $display("FAIL both_exc got=%b exp=%b", x, e.exc); end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL both_rdy_end rdy/busy not low after DONE"); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic x, b0, ok;
        int k;
        bit seen;
        int act = 0;
        exp_t e;
        ctrl_MULT = 1'b1; data_operandA = 32'h0000_1234; data_operandB = 32'h0000_5678;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (15) @(negedge clock);
        ctrl_reset = 1'b1;
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (data_result !== 32'd0) begin bad++; $display("FAIL midreset_result got=%h exp=0", data_result); end
        total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL midreset_exc got=%b exp=0", data_exception); end
        ctrl_reset = 1'b0;
        for (int i = 0; i < int'(WIDTH) + 4; i++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) act++;
        end
        total++; if (act != 0) begin bad++; $display("FAIL midreset_no_rdy active cycles=%0d exp=0", act); end
        do_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678, r, x, k, seen, b0, ok);
        e = sb.pop_front();
        total++; if (!seen || k != e.lat) begin bad++; $display("FAIL fresh_latency got=%0d seen=%0d exp=%0d", k, seen, e.lat); end
        total++; if (r !== e.res || x !== e.exc) begin bad++; $display("FAIL fresh_result got=%h/%b exp=%h/%b", r, x, e.res, e.exc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic x, b0, ok;
        int k;
        bit seen;
        exp_t e;
        logic ops[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ta[4] = '{32'hFFFF_FC18, 32'd1000000, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] tb_[4] = '{32'hFFFF_FC18, 32'hFFFF_FFF9, 32'd0, 32'd2};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], !ops[i], ta[i], tb_[i], r, x, k, seen, b0, ok);
            e = sb.pop_front();
            total++; if (b0 !== 1'b1 || !seen || k != e.lat) begin bad++; $display("FAIL b2b_timing i=%0d busy=%b lat=%0d exp=%0d", i, b0, k, e.lat); end
            total++; if (r !== e.res || x !== e.exc) begin bad++; $display("FAIL b2b_result i=%0d got=%h/%b exp=%h/%b", i, r, x, e.res, e.exc); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
